// File: rtl/serial_tx_8bit.sv
// serial_tx_8bit: 8-bit parallel-to-serial transmitter, MSB first.
// A byte is taken on a load_valid/load_ready handshake. One bit advances
// per clk edge with en=1. A single-cycle done pulse marks the end of the frame.
// Optional feature macro: SERIAL_TX_PARITY_EN. When it is defined, an even-parity
// bit is appended as a ninth bit.

module serial_tx_8bit #(
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load_valid,
    input  logic [7:0] D_par,
    output logic       load_ready,
    output logic       D_out,
    output logic       busy,
    output logic       done
);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Even parity: the parity bit makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t     state_r;
    state_t     state_s;
    logic [7:0] shreg_r;
    logic [2:0] cnt_r;
    logic       done_r;
    logic       handshake_s;
    logic       last_data_s;
    logic       frame_end_s;
`ifdef SERIAL_TX_PARITY_EN
    logic       par_r;
`endif

    assign handshake_s = load_valid & load_ready;
    assign last_data_s = (state_r == ST_SHIFT) & en & (cnt_r == 3'd7);
`ifdef SERIAL_TX_PARITY_EN
    assign frame_end_s = (state_r == ST_PARITY) & en;
`else
    assign frame_end_s = last_data_s;
`endif
    assign done = done_r;

    // State register. Reset takes priority over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (handshake_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_data_s) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_s = ST_PARITY;
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_SHIFT;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (en) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode. In SHIFT, D_out follows bit 7 of the shift register without a register stage.
    always_comb begin
        load_ready = 1'b1;
        busy       = 1'b0;
        D_out      = IDLE_BIT;
        case (state_r)
            ST_IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                D_out      = IDLE_BIT;
            end
            ST_SHIFT: begin
                load_ready = 1'b0;
                busy       = 1'b1;
                D_out      = shreg_r[7];
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                load_ready = 1'b0;
                busy       = 1'b1;
                D_out      = par_r;
            end
`endif
            default: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                D_out      = IDLE_BIT;
            end
        endcase
    end

    // Datapath: capture on handshake, shift on en while in SHIFT, register the done pulse.
    // D_par is sampled only on a handshake. Handshakes can happen only while idle, so
    // load_valid has no effect while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_r <= 8'h00;
            cnt_r   <= 3'd0;
            done_r  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            done_r <= frame_end_s;
            if (handshake_s) begin
                shreg_r <= D_par;
                cnt_r   <= 3'd0;
`ifdef SERIAL_TX_PARITY_EN
                par_r   <= even_parity(D_par);
`endif
            end else if ((state_r == ST_SHIFT) && en) begin
                // The counter wraps from 7 to 0 on the final strobe. No output depends on the counter outside SHIFT.
                shreg_r <= {shreg_r[6:0], 1'b0};
                cnt_r   <= cnt_r + 3'd1;
            end else begin
                shreg_r <= shreg_r;
                cnt_r   <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_8bit.sv
// Directed self-checking bench for serial_tx_8bit (build with SERIAL_TX_PARITY_EN for parity cases).

module tb_serial_tx_8bit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       load_valid;
    logic [7:0] D_par;
    logic       load_ready;
    logic       D_out;
    logic       busy;
    logic       done;

    int total_cnt;
    int bad_cnt;

`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    serial_tx_8bit #(.IDLE_BIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .D_par      (D_par),
        .load_ready (load_ready),
        .D_out      (D_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  byte_v;
    logic [7:0]  rx_v;
    logic [15:0] bits_v;
    logic        exp_bit;

    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        load_valid = 1'b0;
        D_par      = 8'h00;
        tick();
        tick();
        chk("rst_ready", {15'd0, load_ready}, 16'd1);
        chk("rst_busy",  {15'd0, busy},       16'd0);
        chk("rst_dout",  {15'd0, D_out},      16'd0);
        chk("rst_done",  {15'd0, done},       16'd0);
        rst_n = 1'b1;
        tick();

        // Frame 8'hA5 with en held high. Its parity bit is 0 (four ones).
        byte_v     = 8'hA5;
        D_par      = byte_v;
        load_valid = 1'b1;
        en         = 1'b1;
        tick();
        load_valid = 1'b0;
        D_par      = 8'h00;
        for (int i = 0; i < NB; i++) begin
            exp_bit = (i < 8) ? byte_v[7-i] : 1'b0;
            chk("a5_bit",  {15'd0, D_out}, {15'd0, exp_bit});
            chk("a5_busy", {15'd0, busy},  16'd1);
            chk("a5_nodone", {15'd0, done}, 16'd0);
            tick();
        end
        chk("a5_done",  {15'd0, done},       16'd1);
        chk("a5_idle",  {15'd0, busy},       16'd0);
        chk("a5_ready", {15'd0, load_ready}, 16'd1);
        tick();
        chk("a5_done_gone", {15'd0, done},  16'd0);
        chk("a5_idle_dout", {15'd0, D_out}, 16'd0);

        // Frame 8'h3C with en on every third cycle. A loopback receiver samples on each strobe.
        byte_v     = 8'h3C;
        D_par      = byte_v;
        load_valid = 1'b1;
        en         = 1'b0;
        tick();
        load_valid = 1'b0;
        rx_v       = 8'h00;
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < 3; c++) begin
                en      = (c == 2);
                exp_bit = (i < 8) ? byte_v[7-i] : 1'b0;
                chk("3c_hold", {15'd0, D_out}, {15'd0, exp_bit});
                if (c == 2 && i < 8) rx_v = {rx_v[6:0], D_out};
                tick();
            end
        end
        en = 1'b0;
        chk("3c_done", {15'd0, done}, 16'd1);
        chk("3c_rx",   {8'd0, rx_v},  16'h003C);
        tick();

        // Back-to-back frames: the second byte is accepted in the done cycle.
        // D_par changes while busy to show that it is not sampled then.
        en         = 1'b1;
        load_valid = 1'b1;
        D_par      = 8'h81;
        tick();
        D_par  = 8'h7E;
        bits_v = 16'h0000;
        for (int i = 0; i < NB; i++) begin
            if (i < 8) bits_v = {bits_v[14:0], D_out};
            tick();
        end
        chk("b2b_done1",  {15'd0, done},       16'd1);
        chk("b2b_ready1", {15'd0, load_ready}, 16'd1);
        tick();
        load_valid = 1'b0;
        chk("b2b_busy2", {15'd0, busy}, 16'd1);
        for (int i = 0; i < NB; i++) begin
            if (i < 8) bits_v = {bits_v[14:0], D_out};
            tick();
        end
        chk("b2b_done2", {15'd0, done}, 16'd1);
        chk("b2b_bits",  bits_v,        16'h817E);
        tick();
        chk("b2b_idle", {15'd0, busy}, 16'd0);

        // Reset after the fourth strobe of 8'hFF: the frame is aborted and no done pulse follows.
        D_par      = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_mid_dout", {15'd0, D_out}, 16'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_dout",  {15'd0, D_out},      16'd0);
        chk("abort_ready", {15'd0, load_ready}, 16'd1);
        chk("abort_done",  {15'd0, done},       16'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_nodone", {15'd0, done}, 16'd0);
            tick();
        end

        // A reset on the same edge as a handshake wins.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        tick();
        rst_n      = 1'b1;
        load_valid = 1'b0;
        chk("rst_wins_busy", {15'd0, busy}, 16'd0);

`ifdef SERIAL_TX_PARITY_EN
        // Parity bit: 8'h07 has three ones, so the parity bit is 1. 8'h03 has two ones, so it is 0.
        for (int k = 0; k < 2; k++) begin
            byte_v     = (k == 0) ? 8'h07 : 8'h03;
            D_par      = byte_v;
            load_valid = 1'b1;
            en         = 1'b1;
            tick();
            load_valid = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            chk("par_bit",    {15'd0, D_out}, {15'd0, (k == 0)});
            chk("par_busy",   {15'd0, busy},  16'd1);
            chk("par_nodone", {15'd0, done},  16'd0);
            tick();
            chk("par_done", {15'd0, done}, 16'd1);
            tick();
        end
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
